// File: rtl/rca_32_bit.sv
// Registered WIDTH-bit ripple-carry adder: {Cout,Sout} = A + B, one cycle of latency.
// Define RCA_OVF_EN to add the registered signed-overflow output Ovf.
module rca_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Cout,
  output logic [WIDTH-1:0] Sout
`ifdef RCA_OVF_EN
  ,
  output logic             Ovf
`endif
);

  // cin_w[i] is c[i] and cout_w[i] is c[i+1]; cout_w[WIDTH-1] is the final carry-out.
  logic [WIDTH-1:0] cin_w;
  logic [WIDTH-1:0] cout_w;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sout_q;
  logic             cout_q;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      logic p_w;

      if (gi == 0) begin : g_c0
        assign cin_w[gi] = 1'b0;
      end else begin : g_cn
        assign cin_w[gi] = cout_w[gi-1];
      end

      assign p_w        = A[gi] ^ B[gi];
      assign sum_d[gi]  = p_w ^ cin_w[gi];
      assign cout_w[gi] = (A[gi] & B[gi]) | (cin_w[gi] & p_w);
    end
  endgenerate

  assign cout_d = cout_w[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout_q <= '0;
      cout_q <= 1'b0;
    end else begin
      sout_q <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign Sout = sout_q;
  assign Cout = cout_q;

`ifdef RCA_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf_d = cout_w[WIDTH-1] ^ cin_w[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_rca_32_bit.sv
// Self-checking bench for rca_32_bit: directed cases, async reset, and random operands
// against an arithmetic reference model.
module tb_rca_32_bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cout;
  logic [31:0] sout;
`ifdef RCA_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [32:0] last_exp;
  logic        last_ovf;

  rca_32_bit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a),
    .B     (b),
    .Cout  (cout),
    .Sout  (sout)
`ifdef RCA_OVF_EN
    ,
    .Ovf   (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_sum(input logic [31:0] x, input logic [31:0] y);
    longint unsigned s;
    s = longint'(x) + longint'(y);
    return s[32:0];
  endfunction

  function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y);
    longint s;
    s = longint'($signed(x)) + longint'($signed(y));
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic check_outputs(input string tag, input logic [32:0] exp_sum, input logic exp_ovf);
    check_val(tag, {31'b0, cout, sout}, {31'b0, exp_sum});
`ifdef RCA_OVF_EN
    check_val({tag, "_ovf"}, {63'b0, ovf}, {63'b0, exp_ovf});
`else
    if (exp_ovf && !exp_ovf) $display("unreachable");
`endif
  endtask

  // Drive operands at the falling edge, confirm the old result still holds, then
  // check the new result just after the next rising edge.
  task automatic apply(input string tag, input logic [31:0] x, input logic [31:0] y, input bit verbose);
    @(negedge clk);
    a = x;
    b = y;
    #1;
    check_outputs({tag, "_hold"}, last_exp, last_ovf);
    @(posedge clk);
    #1;
    last_exp = ref_sum(x, y);
    last_ovf = ref_ovf(x, y);
    check_outputs(tag, last_exp, last_ovf);
    if (verbose)
      $display("%s: A=0x%08h B=0x%08h -> Cout=%0d Sout=0x%08h", tag, x, y, cout, sout);
  endtask

  initial begin
    rst_n    = 1'b1;
    a        = 32'h0000000C;
    b        = 32'h00000002;
    last_exp = '0;
    last_ovf = 1'b0;

    // Reset asserts between edges and must clear outputs immediately.
    #2 rst_n = 1'b0;
    #1 check_outputs("reset_async", 33'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 check_outputs("reset_hold", 33'h0, 1'b0);
    $display("reset: Cout=%0d Sout=0x%08h", cout, sout);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    last_exp = ref_sum(32'h0000000C, 32'h00000002);
    check_outputs("first_after_reset", last_exp, 1'b0);
    $display("release: Cout=%0d Sout=0x%08h", cout, sout);

    apply("basic_3_3", 32'h00000003, 32'h00000003, 1'b1);
    apply("basic_c_3", 32'h0000000C, 32'h00000003, 1'b1);
    apply("wrap_ff_1", 32'hFFFFFFFF, 32'h00000001, 1'b1);
    apply("wrap_ff_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    apply("b2b_80_80", 32'h80000000, 32'h80000000, 1'b1);
    apply("b2b_7f_1", 32'h7FFFFFFF, 32'h00000001, 1'b1);
    apply("zero_zero", 32'h00000000, 32'h00000000, 1'b1);

    // Reset mid-stream, held across an edge, then released with new operands.
    apply("pre_reset", 32'h12345678, 32'h11111111, 1'b1);
    rst_n = 1'b0;
    #1 check_outputs("midreset_async", 33'h0, 1'b0);
    @(posedge clk);
    #1 check_outputs("midreset_hold", 33'h0, 1'b0);
    @(negedge clk);
    a     = 32'hA5A5A5A5;
    b     = 32'h5A5A5A5B;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    last_exp = ref_sum(32'hA5A5A5A5, 32'h5A5A5A5B);
    last_ovf = ref_ovf(32'hA5A5A5A5, 32'h5A5A5A5B);
    check_outputs("midreset_release", last_exp, last_ovf);
    $display("midreset release: Cout=%0d Sout=0x%08h", cout, sout);

    for (int i = 0; i < 10000; i++) begin
      apply("random", $urandom, $urandom, 1'b0);
    end
    $display("random: 10000 operand pairs applied");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_32_bit.md
Name: rca_32_bit

Overview:
- 32-bit unsigned ripple-carry adder built from a chain of single-bit full-adder cells.
- Carry-in to bit 0 is fixed at 0.
- Sum and carry-out are registered, so the block drops into clocked datapaths as a one-cycle-latency adder stage.

Parameters:
- WIDTH, 32, operand/sum width in bits; the carry chain has WIDTH full-adder stages.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  addend A, unsigned.
- B  input  WIDTH  addend B, unsigned.
- Cout  output  1  registered carry-out of the MSB stage.
- Sout  output  WIDTH  registered sum bits.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports clk and rst_n.
- Datapath:
  - Full adder per bit: s[i] = A[i]^B[i]^c[i]; c[i+1] = (A[i]&B[i]) | (c[i]&(A[i]^B[i])).
  - c[0] = 0.
  - Internal carry vector c[1..WIDTH-1] is WIDTH-1 bits wide (31 for default).
  - c[WIDTH] is the carry-out.
- Arithmetic: {Cout,Sout} = A + B, exact (WIDTH+1)-bit unsigned result, no saturation. Sout wraps modulo 2^WIDTH.
- Implementation style: explicit ripple structure of full-adder instances or generate loop. Not a behavioural "+".
- Registration:
  - Sout and Cout are flops loaded every rising clk edge from the combinational sum of A/B sampled at that edge.
  - Latency is exactly 1 cycle; throughput is 1 result per cycle.
  - No enable, no handshake.
- Reset:
  - rst_n low forces Sout=0 and Cout=0 immediately, independent of clk.
  - Outputs hold 0 while rst_n is low.
  - The first rising edge after rst_n deasserts captures the current A+B.
- Reset mid-operation: an in-flight result is discarded; no stale value appears after release.
- Inputs X/Z: no requirement beyond propagation. Bench drives known values.
- Timing: combinational path A/B to flop D is the full WIDTH-stage ripple. No pipelining inside the chain.

Optional Feature:
- Macro RCA_OVF_EN.
- When defined:
  - Adds output port Ovf (1 bit, registered).
  - Ovf = c[WIDTH] ^ c[WIDTH-1], the two's-complement signed overflow of A+B.
  - Same latency and reset value (0) as Sout.
- When undefined:
  - Port absent.
  - No extra logic.
  - Sout/Cout behaviour identical in both builds.

Test Plan:
- Reset: rst_n=0 with A=0x0000000C, B=0x00000002 -> Sout=0x00000000, Cout=0 asynchronously, held until release.
- Basic: A=0x0000000C, B=0x00000002 -> one edge later Sout=0x0000000E, Cout=0. Then A=B=0x00000003 -> Sout=0x00000006, Cout=0. Then A=0x0000000C, B=0x00000003 -> Sout=0x0000000F, Cout=0. Each result appears exactly 1 cycle after its operands.
- Full ripple/wrap: A=0xFFFFFFFF, B=0x00000001 -> Sout=0x00000000, Cout=1. A=0xFFFFFFFF, B=0xFFFFFFFF -> Sout=0xFFFFFFFE, Cout=1.
- Back-to-back: new operands every cycle (0x80000000+0x80000000, then 0x7FFFFFFF+0x00000001) -> Sout/Cout = 0x00000000/1 then 0x80000000/0 on consecutive cycles. With RCA_OVF_EN: Ovf=1, then 1.
- Reset mid-stream: assert rst_n low between edges while streaming -> outputs go 0 at once. After release, first edge shows the sum of the currently applied operands.
- Random: 10k random A/B pairs vs {Cout,Sout} = A+B reference, checked with 1-cycle delay. With RCA_OVF_EN, Ovf also compared against signed overflow.
